ind_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for the shared `ind`/`status` handshake resource of the `intf` interface.
- Up to NUM_REQ local requesters contend for the single `ind` line. The winner's transaction runs as a four-phase handshake: `ind` up, wait for `status` up, `ind` down, wait for `status` down.
- Sits on the master side of the interface, in front of the `intf` bundle that carries `ind`/`status` down through the wrapper hierarchy to the slave.
- A timeout guard protects against a slave that never responds.

---
 rtl/ind_rr_arbiter_if.sv | 23 ++
 rtl/ind_rr_arbiter.sv | 126 ++++++++++++
 tb/tb_ind_rr_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/ind_rr_arbiter_if.sv
// Request/grant bundle plus the shared ind/status handshake pair.
// The master modport is the arbiter; the slave modport is the requesters together with the responding slave.
interface ind_rr_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] done;
  logic [NUM_REQ-1:0] err;
  logic               ind;
  logic               status;
  logic               busy;

  modport master (
    input  req, status,
    output gnt, done, err, ind, busy
  );

  modport slave (
    output req, status,
    input  gnt, done, err, ind, busy
  );
endinterface

// File: rtl/ind_rr_arbiter.sv
// Round-robin arbiter that sequences a four-phase ind/status handshake with a per-phase timeout.
// Optional macro IND_STATUS_SYNC_EN adds a 2-flop synchronizer on status.
module ind_rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int TIMEOUT   = 255,
  parameter int TIMEOUT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ind_rr_arbiter_if.master      bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0]   ONE      = 1;
  localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ASSERT, RELEASE} state_e;

  state_e               state_q;
  logic [NUM_REQ-1:0]   gnt_q, done_q, err_q;
  logic                 ind_q, busy_q, fail_q;
  logic [IDX_W-1:0]     ptr_q;
  logic [TIMEOUT_W-1:0] cnt_q;
  logic                 status_s;
  logic                 any_d;
  logic [IDX_W-1:0]     win_d;

`ifdef IND_STATUS_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], bus.status};
  end
  assign status_s = sync_q[1];
`else
  assign status_s = bus.status;
`endif

  // First requester strictly after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    int               idx;
    logic [IDX_W-1:0] cand;
    any_d = 1'b0;
    win_d = ptr_q;
    idx   = 0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IDX_W'(idx);
      if (!any_d && bus.req[cand]) begin
        any_d = 1'b1;
        win_d = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      ind_q   <= 1'b0;
      busy_q  <= 1'b0;
      fail_q  <= 1'b0;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      done_q <= '0;
      err_q  <= '0;
      case (state_q)
        IDLE: begin
          if (any_d) begin
            state_q <= ASSERT;
            gnt_q   <= ONE << win_d;
            ind_q   <= 1'b1;
            busy_q  <= 1'b1;
            ptr_q   <= win_d;
            cnt_q   <= '0;
            fail_q  <= 1'b0;
          end
        end
        ASSERT: begin
          if (status_s) begin
            state_q <= RELEASE;
            ind_q   <= 1'b0;
            cnt_q   <= '0;
          end else if (!bus.req[ptr_q] || cnt_q == CNT_LAST) begin
            // Abort and timeout both still run the release phase before reporting.
            state_q <= RELEASE;
            ind_q   <= 1'b0;
            cnt_q   <= '0;
            fail_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + TIMEOUT_W'(1);
          end
        end
        RELEASE: begin
          if (!status_s) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            fail_q  <= 1'b0;
            if (fail_q) err_q[ptr_q]  <= 1'b1;
            else        done_q[ptr_q] <= 1'b1;
          end else if (cnt_q == CNT_LAST) begin
            state_q       <= IDLE;
            gnt_q         <= '0;
            busy_q        <= 1'b0;
            fail_q        <= 1'b0;
            err_q[ptr_q]  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + TIMEOUT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;
  assign bus.ind  = ind_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_ind_rr_arbiter.sv
// Bench for ind_rr_arbiter: vector table, directed corner sequences and randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_ind_rr_arbiter;
  localparam int N = 4;
  localparam int T = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req_drv;
  logic         status_drv;

  always #5 clk = ~clk;

  ind_rr_arbiter_if #(.NUM_REQ(N)) bus();
  assign bus.req    = req_drv;
  assign bus.status = status_drv;

  ind_rr_arbiter #(.NUM_REQ(N), .TIMEOUT(T), .TIMEOUT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: phase 0 idle, 1 waiting for status high, 2 waiting for status low.
  int           m_phase = 0;
  int           m_last  = N - 1;
  int           m_wait  = 0;
  bit           m_bad   = 1'b0;
  logic [N-1:0] m_done  = '0;
  logic [N-1:0] m_err   = '0;

  function automatic logic [N-1:0] m_gnt();
    logic [N-1:0] g;
    g = '0;
    if (m_phase != 0) g[m_last] = 1'b1;
    return g;
  endfunction

  task automatic model_step(input logic [N-1:0] r, input logic s, input logic rn);
    bit found;
    int c;
    m_done = '0;
    m_err  = '0;
    if (!rn) begin
      m_phase = 0; m_last = N - 1; m_wait = 0; m_bad = 1'b0;
    end else if (m_phase == 0) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (!found && r[c]) begin
          found = 1'b1; m_phase = 1; m_last = c; m_wait = 0; m_bad = 1'b0;
        end
      end
    end else if (m_phase == 1) begin
      if (s) begin
        m_phase = 2; m_wait = 0;
      end else if (!r[m_last] || m_wait == T - 1) begin
        m_phase = 2; m_wait = 0; m_bad = 1'b1;
      end else begin
        m_wait++;
      end
    end else begin
      if (!s) begin
        m_phase = 0;
        if (m_bad) m_err[m_last] = 1'b1;
        else       m_done[m_last] = 1'b1;
        m_bad = 1'b0;
      end else if (m_wait == T - 1) begin
        m_phase = 0; m_err[m_last] = 1'b1; m_bad = 1'b0;
      end else begin
        m_wait++;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    model_step(req_drv, status_drv, rst_n);
    @(posedge clk);
    #1;
    chk("model_gnt",  32'(bus.gnt),  32'(m_gnt()));
    chk("model_done", 32'(bus.done), 32'(m_done));
    chk("model_err",  32'(bus.err),  32'(m_err));
    chk("model_ind",  32'(bus.ind),  32'(m_phase == 1));
    chk("model_busy", 32'(bus.busy), 32'(m_phase != 0));
  endtask

  function automatic int idx_of(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  typedef struct {
    logic [N-1:0] req;
    logic         st;
    logic [N-1:0] gnt;
    logic [N-1:0] done;
    logic [N-1:0] err;
    logic         ind;
    logic         busy;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int order[$];
    int ndone;
    int rel;
    logic [N-1:0] prev_gnt;
    logic [N-1:0] err_seen;

    // Single requester with a prompt slave, then a timeout in the raise phase.
    tbl[0]  = '{4'b0001, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b1};
    tbl[1]  = '{4'b0001, 1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b1};
    tbl[2]  = '{4'b0001, 1'b0, 4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b0};
    tbl[3]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
    tbl[4]  = '{4'b0010, 1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b1};
    tbl[5]  = '{4'b0010, 1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b1};
    tbl[6]  = '{4'b0010, 1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b1};
    tbl[7]  = '{4'b0010, 1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b1};
    tbl[8]  = '{4'b0010, 1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b1};
    tbl[9]  = '{4'b0010, 1'b0, 4'b0000, 4'b0000, 4'b0010, 1'b0, 1'b0};
    tbl[10] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};

    req_drv = '0; status_drv = 1'b0; rst_n = 1'b0;
    tick(); tick();
    chk("rst_gnt",  32'(bus.gnt),  32'h0);
    chk("rst_ind",  32'(bus.ind),  32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_done", 32'(bus.done | bus.err), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      req_drv = tbl[i].req; status_drv = tbl[i].st;
      tick();
      chk($sformatf("vec%0d_gnt", i),  32'(bus.gnt),  32'(tbl[i].gnt));
      chk($sformatf("vec%0d_done", i), 32'(bus.done), 32'(tbl[i].done));
      chk($sformatf("vec%0d_err", i),  32'(bus.err),  32'(tbl[i].err));
      chk($sformatf("vec%0d_ind", i),  32'(bus.ind),  32'(tbl[i].ind));
      chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(tbl[i].busy));
    end

    // Round-robin fairness with a slave that mirrors ind.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    req_drv = 4'b1111; ndone = 0; prev_gnt = '0;
    for (int c = 0; c < 200 && ndone < 8; c++) begin
      status_drv = bus.ind;
      tick();
      if (bus.gnt != 0 && prev_gnt == 0) order.push_back(idx_of(bus.gnt));
      if (bus.done != 0) ndone++;
      prev_gnt = bus.gnt;
    end
    chk("rr_done_count", 32'(ndone), 32'd8);
    chk("rr_grant_count", 32'(order.size()), 32'd8);
    for (int i = 0; i < order.size() && i < 8; i++)
      chk($sformatf("rr_order%0d", i), 32'(order[i]), 32'(i % 4));

    // Abort: requester 2 withdraws two cycles into the raise phase.
    req_drv = '0; status_drv = 1'b0; tick();
    req_drv = 4'b0100; tick();
    chk("abort_gnt", 32'(bus.gnt), 32'h4);
    tick(); tick();
    req_drv = '0; tick();
    chk("abort_ind_low", 32'(bus.ind), 32'h0);
    chk("abort_no_err_yet", 32'(bus.err), 32'h0);
    tick();
    chk("abort_err", 32'(bus.err), 32'h4);
    chk("abort_gnt_clr", 32'(bus.gnt), 32'h0);
    chk("abort_no_done", 32'(bus.done), 32'h0);

    // Stuck status: acknowledged, then never released.
    tick();
    req_drv = 4'b1000; tick();
    chk("stuck_gnt", 32'(bus.gnt), 32'h8);
    status_drv = 1'b1; tick();
    rel = 1; err_seen = '0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.busy && !bus.ind) rel++;
      else begin
        err_seen = bus.err;
        break;
      end
    end
    chk("stuck_release_len", 32'(rel), 32'd4);
    chk("stuck_err", 32'(err_seen), 32'h8);
    status_drv = 1'b0; req_drv = 4'b0001; tick();
    chk("stuck_next_gnt", 32'(bus.gnt), 32'h1);

    // Reset while requester 0 is in the raise phase.
    rst_n = 1'b0; tick();
    chk("midrst_ind",  32'(bus.ind),  32'h0);
    chk("midrst_gnt",  32'(bus.gnt),  32'h0);
    chk("midrst_busy", 32'(bus.busy), 32'h0);
    chk("midrst_pulse", 32'(bus.done | bus.err), 32'h0);
    rst_n = 1'b1; req_drv = 4'b1111; tick();
    chk("midrst_regrant", 32'(bus.gnt), 32'h1);

    // Randomized traffic: level requests, occasional aborts, slow or stuck slave, rare resets.
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 399) != 0);
      for (int i = 0; i < N; i++) begin
        if (bus.done[i] || bus.err[i])          req_drv[i] = 1'b0;
        else if (!req_drv[i] && ($urandom % 4 == 0)) req_drv[i] = 1'b1;
        else if (req_drv[i] && ($urandom % 40 == 0)) req_drv[i] = 1'b0;
      end
      if (bus.ind) status_drv = ($urandom % 3 != 0) ? 1'b1 : status_drv;
      else         status_drv = ($urandom % 3 != 0) ? 1'b0 : status_drv;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
